tick_gen: RTL
=============

# tick_gen

Parametrised multi-channel tick generator; successor to the fixed five-output clock divider feeding display, seven-segment, score, player and game logic. It emits single-cycle enable pulses (and optional 50%-duty square waves) per channel from the one system clock, with divisors reprogrammable at run time. Downstream logic runs on `clk` and qualifies with `tick[i]`; no derived clocks are used in the design.

## Interface
Parameters:
- NUM_CH, 5, number of independent channels (1..16)
- CNT_W, 27, counter/divisor width in bits; must hold the largest divisor

Ports:
- clk  in  1  system clock (100 MHz on board)
- clr_n  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes all counters, ticks forced 0
- ch_en  in  NUM_CH  per-channel enable
- sync_restart  in  1  one-cycle pulse; phase-aligns all channels
- div_wr  in  1  divisor write strobe
- div_sel  in  $clog2(NUM_CH) (min 1)  channel written by div_wr
- div_val  in  CNT_W  new divisor
- tick  out  NUM_CH  one-cycle pulse per channel period
- sq  out  NUM_CH  square wave, toggles on each tick (only with TICK_GEN_SQ_EN)

## Operation
- Per channel: counter `cnt`, active divisor `div`, pending divisor `pend`, pending flag `pv`.
- Reset (clr_n low, async): cnt=0, tick=0, sq=0, pv=0, div=pend=DEFAULT_DIV[i] from package.
- Effective divisor d = max(div,1); values 0 and 1 both give tick high every enabled cycle.
- Enabled cycle (en & ch_en[i]): if cnt==d-1 then cnt<=0, tick<=1, sq<=~sq, and if pv then div<=pend, pv<=0; else cnt<=cnt+1, tick<=0.
- Channel disabled (ch_en[i]=0): cnt<=0, tick<=0, sq held; a pending divisor is applied immediately (div<=pend, pv<=0).
- en=0: cnt, sq, div, pv held; tick<=0.
- div_wr: pend[div_sel]<=div_val, pv<=1; applied at that channel's next wrap (glitch-free period change). div_sel>=NUM_CH: write ignored.
- A second write before the wrap overwrites pend; only the last value is applied.
- sync_restart: all counters <=0, tick<=0, sq<=0; pending divisors applied immediately. Takes priority over wrap in the same cycle.
- div_wr and sync_restart same cycle: written value lands in div immediately, counter starts from 0.
- Arithmetic is unsigned CNT_W; cnt never exceeds d-1, so no wrap-around overflow.

## Timing
- tick is registered; with d=N and enable continuously high from reset release, first tick in cycle N (edges 1..N), then every N cycles; duty 1/N.
- sq period 2N cycles, 50% duty, first rise coincident with first tick.
- div_wr latency: new period starts with the cycle after the next tick.
- sync_restart in cycle k: tick low in k+1, next tick in cycle k+N.
- Reset mid-period: outputs go to 0 asynchronously; restart as from power-up on clr_n release.

## Configuration
- TICK_GEN_SQ_EN defined: sq registers and port present, behaviour above.
- Undefined: sq port absent, no toggle flops; tick behaviour unchanged.

## Structure
- Package tick_gen_pkg: default NUM_CH, CNT_W, channel index constants CH_DCLK=0, CH_SEG=1, CH_SCORE=2, CH_PLR=3, CH_GAME=4, and DEFAULT_DIV array {4, 131072, 50000000, 5000000, 1000000}.
- Sub-module tick_chan: one counter/divisor/pending/sq slice; tick_gen instantiates NUM_CH via generate and decodes div_sel/div_wr.

## Test plan
- Reset, all enables high, write div=4 to every channel then sync_restart -> tick on each channel every 4th cycle, sq period 8.
- ch2 div=5, div_wr div_val=3 mid-period -> current 5-cycle period completes, then 3-cycle periods.
- div_val=0 and 1 on ch0 -> tick high every cycle; sq toggles every cycle.
- ch_en[1] low for 10 cycles then high (div=4) -> no ticks while low, first tick 4 cycles after re-enable; sq holds level.
- sync_restart coincident with ch3 wrap and a div_wr of 6 to ch3 -> no tick next cycle, ch3 ticks 6 cycles later.
- clr_n asserted mid-count -> tick/sq 0 immediately; after release divisors back to DEFAULT_DIV, div_sel=7 write (NUM_CH=5) has no effect.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants for the tick generator.
//   - default channel count / counter width
//   - channel index names for the legacy five-output divider roles
//   - default_div(): reset divisor per channel
//   - sel_w(): width of the channel-select bus (minimum 1)
package tick_gen_pkg;

  localparam int NUM_CH_DEF = 5;
  localparam int CNT_W_DEF  = 27;
  localparam int MAX_CH     = 16;

  localparam int CH_DCLK  = 0;
  localparam int CH_SEG   = 1;
  localparam int CH_SCORE = 2;
  localparam int CH_PLR   = 3;
  localparam int CH_GAME  = 4;

  // Channels past the five named ones come up dividing by 4.
  function automatic logic [31:0] default_div(input int ch);
    case (ch)
      CH_DCLK:  return 32'd4;
      CH_SEG:   return 32'd131072;
      CH_SCORE: return 32'd50000000;
      CH_PLR:   return 32'd5000000;
      CH_GAME:  return 32'd1000000;
      default:  return 32'd4;
    endcase
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// tick_chan: one tick-generator channel.
//   Counter, active divisor, pending divisor + flag, registered tick and
//   (with TICK_GEN_SQ_EN) a square-wave flop toggled on each tick.
// Ports:
//   clk, clr_n      clock, async active-low reset
//   en              global enable (low: freeze, tick forced low)
//   ch_en           channel enable (low: counter cleared, pending applied)
//   sync_restart    phase-align: counter/tick/sq cleared, pending applied
//   wr, wr_val      divisor write for this channel
//   tick            one-cycle pulse per period
//   sq              50% square wave (TICK_GEN_SQ_EN only)
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             ch_en,
  input  logic             sync_restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             tick
`ifdef TICK_GEN_SQ_EN
  ,
  output logic             sq
`endif
);

  logic [CNT_W-1:0] cnt, div, pend, last;
  logic             pv;
  logic             wrap;

  // Divisors 0 and 1 both mean "every cycle": last count is 0.
  assign last = (div == '0) ? '0 : div - CNT_W'(1);
  assign wrap = (cnt == last);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      div  <= DEF_DIV;
      pend <= DEF_DIV;
      pv   <= 1'b0;
    end else if (sync_restart || (en && !ch_en)) begin
      // Restart or disabled channel: nothing in flight, so a new divisor
      // can take effect at once (a same-cycle write wins over older pend).
      cnt  <= '0;
      tick <= 1'b0;
      if (wr) begin
        div  <= wr_val;
        pend <= wr_val;
        pv   <= 1'b0;
      end else if (pv) begin
        div <= pend;
        pv  <= 1'b0;
      end
    end else if (!en) begin
      tick <= 1'b0;
      if (wr) begin
        pend <= wr_val;
        pv   <= 1'b1;
      end
    end else begin
      if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        if (pv) begin
          div <= pend;
          pv  <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A write landing on a wrap edge waits for the following wrap.
      if (wr) begin
        pend <= wr_val;
        pv   <= 1'b1;
      end
    end
  end

`ifdef TICK_GEN_SQ_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                   sq <= 1'b0;
    else if (sync_restart)        sq <= 1'b0;
    else if (en && ch_en && wrap) sq <= ~sq;
  end
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: parametrised multi-channel tick generator.
//   Emits single-cycle enable pulses per channel from clk; divisors are
//   reprogrammable at run time and change only at a period boundary.
//   Optional square-wave outputs when TICK_GEN_SQ_EN is defined.
// Ports:
//   clk, clr_n              clock, async active-low reset
//   en                      global enable
//   ch_en[NUM_CH]           per-channel enable
//   sync_restart            phase-align all channels
//   div_wr, div_sel, div_val divisor write (div_sel >= NUM_CH ignored)
//   tick[NUM_CH]            per-channel tick pulse
//   sq[NUM_CH]              per-channel square wave (TICK_GEN_SQ_EN)
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     sync_restart,
  input  logic                     div_wr,
  input  logic [sel_w(NUM_CH)-1:0] div_sel,
  input  logic [CNT_W-1:0]         div_val,
  output logic [NUM_CH-1:0]        tick
`ifdef TICK_GEN_SQ_EN
  ,
  output logic [NUM_CH-1:0]        sq
`endif
);

  localparam int SEL_W = sel_w(NUM_CH);

  logic [NUM_CH-1:0] wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range selects match no channel, so the write is dropped.
    assign wr[i] = div_wr && (div_sel == SEL_W'(i));

    tick_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(CNT_W'(default_div(i)))
    ) u_chan (
      .clk         (clk),
      .clr_n       (clr_n),
      .en          (en),
      .ch_en       (ch_en[i]),
      .sync_restart(sync_restart),
      .wr          (wr[i]),
      .wr_val      (div_val),
      .tick        (tick[i])
`ifdef TICK_GEN_SQ_EN
      ,
      .sq          (sq[i])
`endif
    );
  end

endmodule
